// File: rtl/target_round_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : target_round_fsm_if                                            |
// | Purpose   : Round control inputs and target/result outputs of the reflex   |
// |             trainer game-logic stage. BEST_TIME_EN adds best_ms.           |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface target_round_fsm_if;
    logic        en;
    logic        btn;
    logic [9:0]  target_x;
    logic [9:0]  target_y;
    logic        target_visible;
    logic        result_valid;
    logic        hit;
    logic        early;
    logic [10:0] reaction_ms;
`ifdef BEST_TIME_EN
    logic [10:0] best_ms;
`endif

    // master drives the player controls; slave is the round FSM
    modport master (
        output en,
        output btn,
`ifdef BEST_TIME_EN
        input  best_ms,
`endif
        input  target_x,
        input  target_y,
        input  target_visible,
        input  result_valid,
        input  hit,
        input  early,
        input  reaction_ms
    );

    modport slave (
        input  en,
        input  btn,
`ifdef BEST_TIME_EN
        output best_ms,
`endif
        output target_x,
        output target_y,
        output target_visible,
        output result_valid,
        output hit,
        output early,
        output reaction_ms
    );
endinterface
`default_nettype wire

// File: rtl/target_round_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : target_round_fsm                                               |
// | Purpose   : Timed reflex rounds: random wait, random target, reaction time.|
// |             Optional macro BEST_TIME_EN adds a best-reaction register.     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module target_round_fsm #(
    parameter int TICK_DIV     = 100000,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int TARGET_SIZE  = 32,
    parameter int MIN_DELAY_MS = 500,
    parameter int TIMEOUT_MS   = 1000,
    parameter int RESULT_MS    = 250
) (
    input wire                 clk,
    input wire                 rst,
    target_round_fsm_if.slave  bus
);
    localparam int          c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [9:0]  c_X_SPAN    = 10'(H_ACTIVE - TARGET_SIZE);
    localparam logic [9:0]  c_Y_SPAN    = 10'(V_ACTIVE - TARGET_SIZE);
    localparam logic [10:0] c_MIN_DELAY = 11'(MIN_DELAY_MS);
    localparam logic [10:0] c_TIMEOUT   = 11'(TIMEOUT_MS);
    localparam logic [10:0] c_RES_LEN   = 11'(RESULT_MS);
    localparam logic [10:0] c_MS_MAX    = 11'h7FF;
    localparam logic [15:0] c_SEED      = 16'hACE1;
    localparam logic [15:0] c_MASK      = 16'hB400;

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_DELAY     = 2'd1;
    localparam logic [1:0]  c_SHOW      = 2'd2;
    localparam logic [1:0]  c_RESULT    = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [c_PW-1:0] presc_q, presc_d;
    logic [10:0]     ms_q, ms_d;
    logic            first_q;
    logic [10:0]     delay_q, delay_d;
    logic [9:0]      tx_q, tx_d;
    logic [9:0]      ty_q, ty_d;
    logic            hit_q, hit_d;
    logic            early_q, early_d;
    logic [10:0]     react_q, react_d;

    logic            w_tick;
    logic [10:0]     w_ms_next;
    logic            w_entry;
    logic            w_delay_entry;
    logic            w_result_load;
    logic [9:0]      w_x_raw;
    logic [9:0]      w_y_raw;
    logic            w_visible;
    logic            w_result_valid;

    assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ c_MASK) : (lfsr_q >> 1);
    assign w_tick    = (presc_q == c_TICK_LAST);
    assign w_ms_next = (ms_q == c_MS_MAX) ? ms_q : ms_q + 11'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; en low always wins, then the press, then the timer
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (bus.en) state_d = c_DELAY;
            end
            c_DELAY: begin
                if (!bus.en)                              state_d = c_IDLE;
                else if (bus.btn)                         state_d = c_RESULT;
                else if (w_tick && w_ms_next >= delay_q)  state_d = c_SHOW;
            end
            c_SHOW: begin
                if (!bus.en)                              state_d = c_IDLE;
                else if (bus.btn)                         state_d = c_RESULT;
                else if (w_tick && w_ms_next >= c_TIMEOUT) state_d = c_RESULT;
            end
            default: begin
                if (!bus.en)                              state_d = c_IDLE;
                else if (w_tick && w_ms_next >= c_RES_LEN) state_d = c_DELAY;
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_visible      = (state_q == c_SHOW);
        w_result_valid = (state_q == c_RESULT) && first_q;
    end

    assign w_entry       = (state_d != state_q);
    assign w_delay_entry = (state_d == c_DELAY) && (state_q != c_DELAY);
    assign w_result_load = (state_d == c_RESULT) && (state_q != c_RESULT);

    // Sample the LFSR value that is current during the first DELAY cycle
    assign w_x_raw = lfsr_d[15:6];
    assign w_y_raw = {1'b0, lfsr_d[8:0]};

    always_comb begin
        presc_d = presc_q + 1'b1;
        ms_d    = ms_q;
        if (w_entry) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (w_tick) begin
            presc_d = '0;
            ms_d    = w_ms_next;
        end

        delay_d = delay_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        if (w_delay_entry) begin
            delay_d = c_MIN_DELAY + {1'b0, lfsr_d[9:0]};
            tx_d    = (w_x_raw >= c_X_SPAN) ? w_x_raw - c_X_SPAN : w_x_raw;
            ty_d    = (w_y_raw >= c_Y_SPAN) ? w_y_raw - c_Y_SPAN : w_y_raw;
        end

        hit_d   = hit_q;
        early_d = early_q;
        react_d = react_q;
        if (w_result_load) begin
            if (state_q == c_DELAY) begin
                hit_d   = 1'b0;
                early_d = 1'b1;
                react_d = '0;
            end else if (bus.btn) begin
                hit_d   = 1'b1;
                early_d = 1'b0;
                react_d = ms_q;
            end else begin
                hit_d   = 1'b0;
                early_d = 1'b0;
                react_d = c_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= c_SEED;
            presc_q <= '0;
            ms_q    <= '0;
            first_q <= 1'b0;
            delay_q <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            hit_q   <= 1'b0;
            early_q <= 1'b0;
            react_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            first_q <= w_entry;
            delay_q <= delay_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            hit_q   <= hit_d;
            early_q <= early_d;
            react_q <= react_d;
        end
    end

`ifdef BEST_TIME_EN
    logic [10:0] best_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= 11'h7FF;
        end else if (w_result_load && hit_d && (react_d < best_q)) begin
            best_q <= react_d;
        end
    end

    assign bus.best_ms = best_q;
`endif

    assign bus.target_x       = tx_q;
    assign bus.target_y       = ty_q;
    assign bus.target_visible = w_visible;
    assign bus.result_valid   = w_result_valid;
    assign bus.hit            = hit_q;
    assign bus.early          = early_q;
    assign bus.reaction_ms    = react_q;

endmodule
`default_nettype wire
